sum_stage: RTL and testbench

Registered sum/flag stage of the prefix adder, placed directly downstream of the Kogge-Stone prefix tree. Takes bit-level propagate and the tree's group propagate/generate outputs, forms carries, sum, carry-out and status flags, and presents them through a two-entry skid buffer with valid/ready handshake. This allows the adder datapath to be pipelined behind a back-pressurable consumer without a combinational ready path.

---
 rtl/prefix_adder_pkg.sv | 31 +++
 rtl/sum_skid_buf.sv | 77 +++++++
 rtl/sum_stage.sv | 105 ++++++++++
 tb/tb_sum_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the prefix adder datapath.
// Build option: SUM_STAGE_SAT_EN enables saturating results in sum_stage.
package prefix_adder_pkg;

  localparam int SUM_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // Result record at the default adder width, as carried between stages.
  typedef struct packed {
    logic [SUM_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
  } sum_result_t;

  // Largest positive two's-complement value of the given width (0x7F..F).
  function automatic logic [63:0] sat_pos_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of the given width (0x80..0).
  function automatic logic [63:0] sat_neg_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sum_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides; o_Ready comes from
// the state register only, so no combinational path from i_Ready to o_Ready.
module sum_skid_buf
  import prefix_adder_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Valid,
  output logic          o_Ready,
  input  logic [DW-1:0] i_Data,
  output logic          o_Valid,
  input  logic          i_Ready,
  output logic [DW-1:0] o_Data
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          accept;
  logic          consume;

  assign o_Ready = (state_q != FULL);
  assign o_Valid = (state_q != EMPTY);
  assign o_Data  = out_q;

  // Next state and data movement between input, output reg and skid reg.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    accept  = i_Valid && (state_q != FULL);
    consume = (state_q != EMPTY) && i_Ready;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = i_Data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          out_d = i_Data;
        end else if (accept) begin
          skid_d  = i_Data;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and data registers; reset discards everything held.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/sum_stage.sv
// Sum/flag stage after the Kogge-Stone tree: forms carries, sum, carry-out,
// overflow and zero, then registers them through a two-entry skid buffer.
// Build option: define SUM_STAGE_SAT_EN to clamp overflowing results when i_Sat=1.
module sum_stage
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_Bit_Pass,
  input  logic [WIDTH-1:0] i_Pass,
  input  logic [WIDTH-1:0] i_Gen,
  input  logic             i_Cin,
  input  logic             i_Sat,
  input  logic             i_Signed,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout,
  output logic             o_Ovf,
  output logic             o_Zero
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } result_t;

  localparam int DW = $bits(result_t);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_final;
  logic             ovf;
  result_t          res_in;
  result_t          res_out;
  logic [DW-1:0]    buf_out;

  // Carries come straight from the group terms: c[j] = G[j-1] | P[j-1]&cin.
  always_comb begin
    carry   = {i_Gen | (i_Pass & {WIDTH{i_Cin}}), i_Cin};
    sum_raw = i_Bit_Pass ^ carry[WIDTH-1:0];
    ovf     = i_Signed ? (carry[WIDTH] ^ carry[WIDTH-1]) : carry[WIDTH];
  end

`ifdef SUM_STAGE_SAT_EN
  localparam logic [63:0] SAT_POS = sat_pos_max(WIDTH);
  localparam logic [63:0] SAT_NEG = sat_neg_min(WIDTH);

  // Clamp on overflow; the sign of the operands is given by c[W] in signed mode.
  always_comb begin
    sum_final = sum_raw;
    if (i_Sat && ovf) begin
      if (!i_Signed) begin
        sum_final = '1;
      end else if (carry[WIDTH]) begin
        sum_final = SAT_NEG[WIDTH-1:0];
      end else begin
        sum_final = SAT_POS[WIDTH-1:0];
      end
    end
  end
`else
  logic unused_sat;
  assign unused_sat = i_Sat;

  // Without saturation the result always wraps.
  always_comb begin
    sum_final = sum_raw;
  end
`endif

  // Zero flag reflects the value actually delivered.
  always_comb begin
    res_in.sum  = sum_final;
    res_in.cout = carry[WIDTH];
    res_in.ovf  = ovf;
    res_in.zero = (sum_final == '0);
  end

  sum_skid_buf #(
    .DW(DW)
  ) u_skid (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .i_Data  (res_in),
    .o_Valid (o_Valid),
    .i_Ready (i_Ready),
    .o_Data  (buf_out)
  );

  assign res_out = result_t'(buf_out);
  assign o_Sum   = res_out.sum;
  assign o_Cout  = res_out.cout;
  assign o_Ovf   = res_out.ovf;
  assign o_Zero  = res_out.zero;

endmodule

// File: tb/tb_sum_stage.sv
// Testbench for sum_stage: directed vectors, back-pressure, reset while full,
// and a randomized handshake run against a behavioural adder model.
module tb_sum_stage;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          i_Rst;
  logic          i_Valid;
  logic          o_Ready;
  logic [W-1:0]  i_Bit_Pass;
  logic [W-1:0]  i_Pass;
  logic [W-1:0]  i_Gen;
  logic          i_Cin;
  logic          i_Sat;
  logic          i_Signed;
  logic          o_Valid;
  logic          i_Ready;
  logic [W-1:0]  o_Sum;
  logic          o_Cout;
  logic          o_Ovf;
  logic          o_Zero;

  int            num_compared   = 0;
  int            num_mismatched = 0;
  logic [18:0]   cur_exp;
  logic [18:0]   exp_q[$];
  logic [15:0]   ra, rb;

  always #5 clk = ~clk;

  sum_stage #(.WIDTH(W)) dut (
    .i_Clk      (clk),
    .i_Rst      (i_Rst),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .i_Bit_Pass (i_Bit_Pass),
    .i_Pass     (i_Pass),
    .i_Gen      (i_Gen),
    .i_Cin      (i_Cin),
    .i_Sat      (i_Sat),
    .i_Signed   (i_Signed),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Sum      (o_Sum),
    .o_Cout     (o_Cout),
    .o_Ovf      (o_Ovf),
    .o_Zero     (o_Zero)
  );

  // Behavioural reference: plain addition, sign rule from operand/result signs.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sgn, input logic sat);
    logic [16:0] full;
    logic [15:0] s;
    logic        co, ov;
    full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    s    = full[15:0];
    co   = full[16];
    ov   = sgn ? ((a[15] == b[15]) && (s[15] != a[15])) : co;
`ifdef SUM_STAGE_SAT_EN
    if (sat && ov) s = sgn ? (a[15] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`else
    if (sat && 1'b0) s = 16'h0000;
`endif
    return {s, co, ov, (s == 16'h0000)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_compared++;
    if (obs !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [18:0] e);
    checkOutput({tag, ".sum"},  32'(o_Sum),  32'(e[18:3]));
    checkOutput({tag, ".cout"}, 32'(o_Cout), 32'(e[2]));
    checkOutput({tag, ".ovf"},  32'(o_Ovf),  32'(e[1]));
    checkOutput({tag, ".zero"}, 32'(o_Zero), 32'(e[0]));
  endtask

  // Drive operands in prefix-tree form (bit P, group P/G) plus mode bits.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sgn, input logic sat);
    logic [15:0] p, g, gp, gg;
    p = a ^ b;
    g = a & b;
    gp[0] = p[0];
    gg[0] = g[0];
    for (int j = 1; j < 16; j++) begin
      gg[j] = g[j] | (p[j] & gg[j-1]);
      gp[j] = p[j] & gp[j-1];
    end
    i_Bit_Pass = p;
    i_Pass     = gp;
    i_Gen      = gg;
    i_Cin      = cin;
    i_Signed   = sgn;
    i_Sat      = sat;
    cur_exp    = model(a, b, cin, sgn, sat);
  endtask

  // One transaction with i_Ready high, hand-computed expected result.
  task automatic runSingle(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sgn, input logic sat,
                           input logic [18:0] e);
    applyStimulus(a, b, cin, sgn, sat);
    i_Valid = 1'b1;
    i_Ready = 1'b1;
    @(negedge clk);
    i_Valid = 1'b0;
    checkOutput({tag, ".valid"}, 32'(o_Valid), 32'd1);
    checkResult(tag, e);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    i_Rst = 1'b1;
    i_Valid = 1'b0;
    i_Ready = 1'b0;
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst.valid", 32'(o_Valid), 32'd0);
    checkOutput("rst.ready", 32'(o_Ready), 32'd1);
    checkResult("rst", 19'd0);
    i_Rst = 1'b0;
    @(negedge clk);

    runSingle("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0100, 3'b000});
    runSingle("wrap_u",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b111});
    runSingle("cin",      16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, {16'h1235, 3'b000});
    runSingle("cin_wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, {16'h0000, 3'b111});
    runSingle("s_noovf",  16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, {16'hFFFE, 3'b100});
`ifdef SUM_STAGE_SAT_EN
    runSingle("s_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, {16'h7FFF, 3'b010});
    runSingle("s_ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, {16'h8000, 3'b110});
    runSingle("u_sat",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'hFFFF, 3'b110});
`else
    runSingle("s_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, {16'h8000, 3'b010});
    runSingle("s_ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, {16'h0000, 3'b111});
    runSingle("u_sat",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h0000, 3'b111});
`endif
    runSingle("s_ovf_nosat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, {16'h8000, 3'b010});

    // Back-pressure: three cycles with i_Ready low while 1,2,3 are offered.
    i_Ready = 1'b0;
    applyStimulus(16'd1, 16'd0, 1'b0, 1'b0, 1'b0);
    i_Valid = 1'b1;
    @(negedge clk);
    checkOutput("bp.ready_a", 32'(o_Ready), 32'd1);
    checkOutput("bp.valid_a", 32'(o_Valid), 32'd1);
    checkOutput("bp.sum_a",   32'(o_Sum),   32'd1);
    applyStimulus(16'd2, 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp.ready_b", 32'(o_Ready), 32'd0);
    checkOutput("bp.sum_b",   32'(o_Sum),   32'd1);
    applyStimulus(16'd3, 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp.ready_c", 32'(o_Ready), 32'd0);
    checkOutput("bp.sum_c",   32'(o_Sum),   32'd1);
    i_Ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.sum_d",   32'(o_Sum),   32'd2);
    checkOutput("bp.ready_d", 32'(o_Ready), 32'd1);
    @(negedge clk);
    i_Valid = 1'b0;
    checkOutput("bp.sum_e",   32'(o_Sum),   32'd3);
    checkOutput("bp.valid_e", 32'(o_Valid), 32'd1);
    @(negedge clk);
    checkOutput("bp.valid_f", 32'(o_Valid), 32'd0);

    // Reset while FULL: held data must never appear.
    i_Ready = 1'b0;
    applyStimulus(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
    i_Valid = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rf.full_ready", 32'(o_Ready), 32'd0);
    i_Valid = 1'b0;
    i_Rst = 1'b1;
    i_Ready = 1'b1;
    @(negedge clk);
    i_Rst = 1'b0;
    checkOutput("rf.valid", 32'(o_Valid), 32'd0);
    checkOutput("rf.ready", 32'(o_Ready), 32'd1);
    checkResult("rf", 19'd0);
    @(negedge clk);
    checkOutput("rf.valid_next", 32'(o_Valid), 32'd0);

    // Random operands and handshakes, scoreboard keeps order.
    for (int n = 0; n < 400; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      i_Valid = ($urandom_range(0, 3) != 0);
      i_Ready = ($urandom_range(0, 2) != 0);
      if (o_Valid && i_Ready) begin
        if (exp_q.size() == 0) checkOutput("rand.unexpected", 32'd1, 32'd0);
        else checkResult("rand", exp_q.pop_front());
      end
      if (i_Valid && o_Ready) exp_q.push_back(cur_exp);
      @(negedge clk);
    end

    i_Valid = 1'b0;
    i_Ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      if (o_Valid) checkResult("drain", exp_q.pop_front());
      @(negedge clk);
      guard++;
    end
    checkOutput("drain.left", 32'(exp_q.size()), 32'd0);
    checkOutput("drain.valid", 32'(o_Valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
